// File: rtl/mul_seq_pkg.sv
// ============================================================================
// Module   : mul_seq_pkg
// Purpose  : Shared definitions for the iterative shift-add multiplier.
//            Holds the operation codes (RISC-V M-extension multiply variants),
//            the FSM state type and helpers that decode per-operand signedness.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mul_seq_pkg;

  // Operation codes presented on the op port
  localparam logic [1:0] MUL_OP_MUL    = 2'd0;  // signed * signed, low word
  localparam logic [1:0] MUL_OP_MULH   = 2'd1;  // signed * signed, high word
  localparam logic [1:0] MUL_OP_MULHSU = 2'd2;  // signed * unsigned, high word
  localparam logic [1:0] MUL_OP_MULHU  = 2'd3;  // unsigned * unsigned, high word

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Multiplicand is signed for every op except MULHU
  function automatic logic op_a_signed(input logic [1:0] op);
    return (op != MUL_OP_MULHU);
  endfunction

  // Multiplier is signed only for MUL and MULH; MULHSU treats it as unsigned
  function automatic logic op_b_signed(input logic [1:0] op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_seq_abs.sv
// ============================================================================
// Module   : mul_seq_abs
// Purpose  : Combinational sign-select and magnitude for one operand.
//            When the operand is treated as signed and is negative, the
//            two's-complement magnitude is produced as a WIDTH-bit unsigned
//            value (the most negative value maps to 2^(WIDTH-1)).
// Ports    : i_val       operand
//            i_is_signed operand is interpreted as two's complement
//            o_mag       unsigned magnitude
//            o_neg       operand is negative
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_seq_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_is_signed,
  output logic [WIDTH-1:0] o_mag,
  output logic             o_neg
);

  assign o_neg = i_is_signed & i_val[WIDTH-1];
  assign o_mag = o_neg ? (-i_val) : i_val;

endmodule

`default_nettype wire

// File: rtl/mul_seq.sv
// ============================================================================
// Module   : mul_seq
// Purpose  : Parametrised iterative shift-add multiplier supporting
//            MUL / MULH / MULHSU / MULHU. Operands are reduced to magnitudes
//            on accept, multiplied unsigned one bit per cycle into a
//            2*WIDTH accumulator, and the sign is re-applied in DONE.
// Ports    : clk       clock, all state on rising edge
//            rst       synchronous active-high reset
//            a, b      multiplicand / multiplier, sampled on accept
//            op        operation code (see mul_seq_pkg)
//            valid     request, accepted when the FSM is IDLE
//            busy      high while in CALC or DONE
//            ready     one-cycle pulse, res/res_word valid
//            res       full 2*WIDTH product
//            res_word  low word for MUL, high word otherwise
// Config   : MUL_SEQ_EARLY_OUT_EN - when defined, CALC ends as soon as the
//            remaining multiplier bits are all zero (data-dependent latency).
//            Undefined (default): constant WIDTH+1 cycle latency.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  input  logic                 valid,
  output logic                 busy,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   res,
  output logic [WIDTH-1:0]     res_word
);

  localparam int              PW       = 2 * WIDTH;
  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mul_state_e        state_q, state_d;
  logic [PW-1:0]     ma_q, ma_d;
  logic [WIDTH-1:0]  mb_q, mb_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [1:0]        op_q, op_d;
  logic [PW-1:0]     res_q, res_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic [WIDTH-1:0]  w_mag_a, w_mag_b;
  logic              w_neg_a, w_neg_b;
  logic              w_early_stop;
  logic [PW-1:0]     w_res_final;

  mul_seq_abs #(.WIDTH(WIDTH)) u_abs_a (
    .i_val       (a),
    .i_is_signed (op_a_signed(op)),
    .o_mag       (w_mag_a),
    .o_neg       (w_neg_a)
  );

  mul_seq_abs #(.WIDTH(WIDTH)) u_abs_b (
    .i_val       (b),
    .i_is_signed (op_b_signed(op)),
    .o_mag       (w_mag_b),
    .o_neg       (w_neg_b)
  );

`ifdef MUL_SEQ_EARLY_OUT_EN
  // No multiplier bits left: every remaining step would add nothing
  assign w_early_stop = (mb_q == '0);
`else
  assign w_early_stop = 1'b0;
`endif

  assign w_res_final = neg_q ? (-acc_q) : acc_q;

  always_comb begin
    state_d = state_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    op_d    = op_q;
    res_d   = res_q;
    word_d  = word_q;
    ready_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          ma_d    = {{WIDTH{1'b0}}, w_mag_a};
          mb_d    = w_mag_b;
          // A zero operand forces a positive result so no sign is re-applied
          neg_d   = (w_neg_a ^ w_neg_b) & (|w_mag_a) & (|w_mag_b);
          acc_d   = '0;
          cnt_d   = CNT_LOAD;
          op_d    = op;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        if (w_early_stop) begin
          state_d = ST_DONE;
        end else begin
          if (mb_q[0]) begin
            acc_d = acc_q + ma_q;
          end
          ma_d  = ma_q << 1;
          mb_d  = mb_q >> 1;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        res_d   = w_res_final;
        word_d  = (op_q == MUL_OP_MUL) ? w_res_final[WIDTH-1:0]
                                       : w_res_final[PW-1:WIDTH];
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      op_q    <= '0;
      res_q   <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      op_q    <= op_d;
      res_q   <= res_d;
      word_q  <= word_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign ready    = ready_q;
  assign res      = res_q;
  assign res_word = word_q;

endmodule

`default_nettype wire
